// File: rtl/sdram_mport_arbit.sv
// Multi-port SDRAM bus arbiter: init phase, refresh priority, round-robin
// channel grants with one NOP cycle between any two owners of the bus.
module sdram_mport_arbit #(
    parameter int unsigned NCH = 4,
    parameter int unsigned AW  = 13,
    parameter int unsigned BW  = 2,
    parameter int unsigned DW  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BW-1:0]     init_ban,
    input  logic [AW-1:0]     init_addr,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [BW-1:0]     aref_ban,
    input  logic [AW-1:0]     aref_addr,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH-1:0]    ch_end,
    input  logic [4*NCH-1:0]  ch_cmd,
    input  logic [BW*NCH-1:0] ch_ban,
    input  logic [AW*NCH-1:0] ch_addr,
    input  logic [NCH-1:0]    ch_dq_oe,
    input  logic [DW*NCH-1:0] ch_dq,
    output logic              aref_en,
    output logic [NCH-1:0]    ch_en,
    output logic [2:0]        cur_ch,
    output logic              preempt,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BW-1:0]     sdram_ban,
    output logic [AW-1:0]     sdram_addr,
    output logic [DW-1:0]     sdram_dq_o,
    output logic              sdram_dq_oe
);

    localparam int unsigned PW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [3:0]  CMD_NOP = 4'b0111;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_AREF  = 2'd2,
        ST_GRANT = 2'd3
    } state_t;

    state_t          state, state_nx, out_st;
    logic [PW-1:0]   ptr, ptr_nx;
    logic [2:0]      cur_ch_nx;
    logic            aref_en_nx;
    logic [NCH-1:0]  ch_en_nx;
    logic [PW-1:0]   cur_idx;
    logic            found;
    logic [PW-1:0]   pick, cand;
    logic [3:0]      cmd;

    // per-channel views of the packed drive buses
    logic [3:0]      cmd_a  [NCH];
    logic [BW-1:0]   ban_a  [NCH];
    logic [AW-1:0]   addr_a [NCH];
    logic [DW-1:0]   dq_a   [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign cmd_a[g]  = ch_cmd[g*4 +: 4];
        assign ban_a[g]  = ch_ban[g*BW +: BW];
        assign addr_a[g] = ch_addr[g*AW +: AW];
        assign dq_a[g]   = ch_dq[g*DW +: DW];
    end

    assign cur_idx   = cur_ch[PW-1:0];
    assign sdram_cke = 1'b1;

    // state, round-robin pointer and grant registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_INIT;
            ptr     <= PW'(NCH - 1);
            cur_ch  <= 3'd0;
            aref_en <= 1'b0;
            ch_en   <= '0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            cur_ch  <= cur_ch_nx;
            aref_en <= aref_en_nx;
            ch_en   <= ch_en_nx;
        end
    end

    // next state: refresh first, then first requester after the last owner
    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        cur_ch_nx  = cur_ch;
        aref_en_nx = aref_en;
        ch_en_nx   = ch_en;
        found      = 1'b0;
        pick       = ptr;
        cand       = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            cand = PW'((32'(ptr) + k) % NCH);
            if (!found && ch_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        case (state)
            ST_INIT: begin
                if (init_end) state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                if (aref_req) begin
                    state_nx   = ST_AREF;
                    aref_en_nx = 1'b1;
                end else if (found) begin
                    state_nx  = ST_GRANT;
                    cur_ch_nx = 3'(pick);
                    ch_en_nx  = NCH'(1) << pick;
                end
            end
            ST_AREF: begin
                if (aref_end) begin
                    state_nx   = ST_IDLE;
                    aref_en_nx = 1'b0;
                end
            end
            ST_GRANT: begin
                if (ch_end[cur_idx]) begin
                    state_nx = ST_IDLE;
                    ch_en_nx = '0;
                    ptr_nx   = cur_idx;
                end
            end
            default: state_nx = ST_INIT;
        endcase
    end

    // bus mux; reset forces the init view immediately
    always_comb begin
        out_st      = rst ? ST_INIT : state;
        cmd         = CMD_NOP;
        sdram_ban   = '0;
        sdram_addr  = '0;
        sdram_dq_o  = '0;
        sdram_dq_oe = 1'b0;
        preempt     = 1'b0;
        case (out_st)
            ST_INIT: begin
                cmd        = init_cmd;
                sdram_ban  = init_ban;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                cmd        = aref_cmd;
                sdram_ban  = aref_ban;
                sdram_addr = aref_addr;
            end
            ST_GRANT: begin
                cmd         = cmd_a[cur_idx];
                sdram_ban   = ban_a[cur_idx];
                sdram_addr  = addr_a[cur_idx];
                sdram_dq_o  = dq_a[cur_idx];
                sdram_dq_oe = ch_dq_oe[cur_idx];
                preempt     = aref_req;
            end
            default: ;
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

endmodule

// File: tb/tb_sdram_mport_arbit.sv
// Scoreboard bench for sdram_mport_arbit: NCH=4 and NCH=8 instances.
module tb_sdram_mport_arbit;

    localparam int unsigned AW = 13;
    localparam int unsigned BW = 2;
    localparam int unsigned DW = 16;

    localparam logic [3:0]    NOP       = 4'b0111;
    localparam logic [3:0]    INIT_CMD  = 4'b0010;
    localparam logic [BW-1:0] INIT_BAN  = 2'b11;
    localparam logic [AW-1:0] INIT_ADDR = 13'h0400;
    localparam logic [3:0]    AREF_CMD  = 4'b0001;
    localparam logic [BW-1:0] AREF_BAN  = 2'b01;
    localparam logic [AW-1:0] AREF_ADDR = 13'h0055;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // channel i drive pattern
    function automatic logic [3:0] f_cmd(input int i);
        return 4'(i + 1);
    endfunction
    function automatic logic [BW-1:0] f_ban(input int i);
        return BW'(i);
    endfunction
    function automatic logic [AW-1:0] f_addr(input int i);
        return AW'(256 + i);
    endfunction
    function automatic logic [DW-1:0] f_dq(input int i);
        return DW'(32'hA000 + i);
    endfunction
    function automatic logic f_oe(input int i);
        return i[0];
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    logic [3:0]    init_cmd;
    logic [BW-1:0] init_ban;
    logic [AW-1:0] init_addr;
    logic [3:0]    aref_cmd;
    logic [BW-1:0] aref_ban;
    logic [AW-1:0] aref_addr;

    // ---------------- NCH=4 instance ----------------
    logic          rst4, init_end4, aref_req4, aref_end4;
    logic [3:0]    ch_req4, ch_end4, ch_dq_oe4;
    logic [15:0]   ch_cmd4;
    logic [7:0]    ch_ban4;
    logic [51:0]   ch_addr4;
    logic [63:0]   ch_dq4;
    logic          aref_en4, preempt4, cke4, cs4, ras4, cas4, we4, dq_oe4;
    logic [3:0]    ch_en4;
    logic [2:0]    cur_ch4;
    logic [BW-1:0] ban4;
    logic [AW-1:0] addr4;
    logic [DW-1:0] dq_o4;

    sdram_mport_arbit #(.NCH(4), .AW(AW), .BW(BW), .DW(DW)) dut4 (
        .clk(clk), .rst(rst4), .init_end(init_end4),
        .init_cmd(init_cmd), .init_ban(init_ban), .init_addr(init_addr),
        .aref_req(aref_req4), .aref_end(aref_end4),
        .aref_cmd(aref_cmd), .aref_ban(aref_ban), .aref_addr(aref_addr),
        .ch_req(ch_req4), .ch_end(ch_end4), .ch_cmd(ch_cmd4), .ch_ban(ch_ban4),
        .ch_addr(ch_addr4), .ch_dq_oe(ch_dq_oe4), .ch_dq(ch_dq4),
        .aref_en(aref_en4), .ch_en(ch_en4), .cur_ch(cur_ch4), .preempt(preempt4),
        .sdram_cke(cke4), .sdram_cs_n(cs4), .sdram_ras_n(ras4), .sdram_cas_n(cas4),
        .sdram_we_n(we4), .sdram_ban(ban4), .sdram_addr(addr4),
        .sdram_dq_o(dq_o4), .sdram_dq_oe(dq_oe4)
    );

    // ---------------- NCH=8 instance ----------------
    logic          rst8, init_end8, aref_req8, aref_end8;
    logic [7:0]    ch_req8, ch_end8, ch_dq_oe8;
    logic [31:0]   ch_cmd8;
    logic [15:0]   ch_ban8;
    logic [103:0]  ch_addr8;
    logic [127:0]  ch_dq8;
    logic          aref_en8, preempt8, cke8, cs8, ras8, cas8, we8, dq_oe8;
    logic [7:0]    ch_en8;
    logic [2:0]    cur_ch8;
    logic [BW-1:0] ban8;
    logic [AW-1:0] addr8;
    logic [DW-1:0] dq_o8;

    sdram_mport_arbit #(.NCH(8), .AW(AW), .BW(BW), .DW(DW)) dut8 (
        .clk(clk), .rst(rst8), .init_end(init_end8),
        .init_cmd(init_cmd), .init_ban(init_ban), .init_addr(init_addr),
        .aref_req(aref_req8), .aref_end(aref_end8),
        .aref_cmd(aref_cmd), .aref_ban(aref_ban), .aref_addr(aref_addr),
        .ch_req(ch_req8), .ch_end(ch_end8), .ch_cmd(ch_cmd8), .ch_ban(ch_ban8),
        .ch_addr(ch_addr8), .ch_dq_oe(ch_dq_oe8), .ch_dq(ch_dq8),
        .aref_en(aref_en8), .ch_en(ch_en8), .cur_ch(cur_ch8), .preempt(preempt8),
        .sdram_cke(cke8), .sdram_cs_n(cs8), .sdram_ras_n(ras8), .sdram_cas_n(cas8),
        .sdram_we_n(we8), .sdram_ban(ban8), .sdram_addr(addr8),
        .sdram_dq_o(dq_o8), .sdram_dq_oe(dq_oe8)
    );

    // expected grant sequence: -1 = refresh, otherwise channel index
    int   q4[$];
    int   q8[$];
    logic in_init4 = 1'b1;
    logic in_init8 = 1'b1;
    logic prev_busy4 = 1'b0;
    logic prev_busy8 = 1'b0;
    int   cur_exp4 = 0;
    int   cur_exp8 = 0;

    // monitor NCH=4: grant events against the queue, bus content every cycle
    always @(negedge clk) begin : mon4
        logic busy;
        int   e;
        busy = aref_en4 || (ch_en4 != 4'd0);
        check("cke4", 64'(cke4), 64'(1));
        if (busy && !prev_busy4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL grant4: got aref_en=%0b ch_en=%b, expected no grant", aref_en4, ch_en4);
            end else begin
                e = q4.pop_front();
                cur_exp4 = e;
                if (e < 0) begin
                    check("grant4_aref", 64'({aref_en4, ch_en4}), 64'({1'b1, 4'd0}));
                end else begin
                    check("grant4_ch", 64'({aref_en4, ch_en4}), 64'({1'b0, 4'(1 << e)}));
                    check("grant4_cur", 64'(cur_ch4), 64'(e));
                end
            end
        end
        prev_busy4 = busy;
        if (in_init4)
            check("init4_bus", 64'({cs4, ras4, cas4, we4, ban4, addr4, dq_oe4, preempt4}),
                  64'({INIT_CMD, INIT_BAN, INIT_ADDR, 1'b0, 1'b0}));
        else if (!busy)
            check("idle4_bus", 64'({cs4, ras4, cas4, we4, ban4, addr4, dq_oe4, preempt4}),
                  64'({NOP, 2'b00, 13'h0, 1'b0, 1'b0}));
        else if (aref_en4)
            check("aref4_bus", 64'({cs4, ras4, cas4, we4, ban4, addr4, dq_oe4, preempt4}),
                  64'({AREF_CMD, AREF_BAN, AREF_ADDR, 1'b0, 1'b0}));
        else if (cur_exp4 >= 0)
            check("grant4_bus", {cs4, ras4, cas4, we4, ban4, addr4, dq_o4, dq_oe4, preempt4},
                  {f_cmd(cur_exp4), f_ban(cur_exp4), f_addr(cur_exp4), f_dq(cur_exp4),
                   f_oe(cur_exp4), aref_req4});
    end

    // monitor NCH=8
    always @(negedge clk) begin : mon8
        logic busy;
        int   e;
        busy = aref_en8 || (ch_en8 != 8'd0);
        if (busy && !prev_busy8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL grant8: got aref_en=%0b ch_en=%b, expected no grant", aref_en8, ch_en8);
            end else begin
                e = q8.pop_front();
                cur_exp8 = e;
                check("grant8_ch", 64'({aref_en8, ch_en8}), 64'({1'b0, 8'(1 << e)}));
                check("grant8_cur", 64'(cur_ch8), 64'(e));
            end
        end
        prev_busy8 = busy;
        if (in_init8)
            check("init8_bus", 64'({cs8, ras8, cas8, we8, ban8, addr8, dq_oe8}),
                  64'({INIT_CMD, INIT_BAN, INIT_ADDR, 1'b0}));
        else if (!busy)
            check("idle8_bus", 64'({cs8, ras8, cas8, we8, ban8, addr8, dq_oe8}),
                  64'({NOP, 2'b00, 13'h0, 1'b0}));
        else if (!aref_en8 && cur_exp8 >= 0)
            check("grant8_bus", {cs8, ras8, cas8, we8, ban8, addr8, dq_o8, dq_oe8},
                  {f_cmd(cur_exp8), f_ban(cur_exp8), f_addr(cur_exp8), f_dq(cur_exp8),
                   f_oe(cur_exp8)});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy4(input string tag);
        for (int n = 0; n < 20; n++) begin
            tick();
            if (aref_en4 || ch_en4 != 4'd0) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: got no grant within 20 cycles, expected a grant", tag);
    endtask

    task automatic wait_busy8(input string tag);
        for (int n = 0; n < 20; n++) begin
            tick();
            if (aref_en8 || ch_en8 != 8'd0) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: got no grant within 20 cycles, expected a grant", tag);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        init_cmd  = INIT_CMD;  init_ban = INIT_BAN;  init_addr = INIT_ADDR;
        aref_cmd  = AREF_CMD;  aref_ban = AREF_BAN;  aref_addr = AREF_ADDR;
        rst4 = 1'b1; init_end4 = 1'b0; aref_req4 = 1'b0; aref_end4 = 1'b0;
        ch_req4 = '0; ch_end4 = '0;
        rst8 = 1'b1; init_end8 = 1'b0; aref_req8 = 1'b0; aref_end8 = 1'b0;
        ch_req8 = '0; ch_end8 = '0;
        for (int i = 0; i < 4; i++) begin
            ch_cmd4[i*4 +: 4]    = f_cmd(i);
            ch_ban4[i*BW +: BW]  = f_ban(i);
            ch_addr4[i*AW +: AW] = f_addr(i);
            ch_dq4[i*DW +: DW]   = f_dq(i);
            ch_dq_oe4[i]         = f_oe(i);
        end
        for (int i = 0; i < 8; i++) begin
            ch_cmd8[i*4 +: 4]    = f_cmd(i);
            ch_ban8[i*BW +: BW]  = f_ban(i);
            ch_addr8[i*AW +: AW] = f_addr(i);
            ch_dq8[i*DW +: DW]   = f_dq(i);
            ch_dq_oe8[i]         = f_oe(i);
        end

        // reset and init handshake
        tick(); tick();
        check("rst4_en", 64'({aref_en4, ch_en4, cur_ch4}), 64'(0));
        rst4 = 1'b0;
        tick(); tick();
        check("init4_wait_en", 64'({aref_en4, ch_en4}), 64'(0));
        init_end4 = 1'b1;
        tick();
        in_init4 = 1'b0;
        check("idle4_cmd", 64'({cs4, ras4, cas4, we4}), 64'(NOP));
        check("idle4_en", 64'({aref_en4, ch_en4}), 64'(0));
        init_end4 = 1'b0;
        tick();
        check("init_end_drop4", 64'({cs4, ras4, cas4, we4}), 64'(NOP));

        // round robin, all four requesting
        q4.push_back(0); q4.push_back(1); q4.push_back(2); q4.push_back(3); q4.push_back(0);
        ch_req4 = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_busy4("rr4");
            tick(); tick();
            ch_end4 = 4'(1 << (k % 4));
            if (k == 4) ch_req4 = 4'h0;
            tick();
            ch_end4 = 4'h0;
        end
        tick();

        // refresh wins over a simultaneous channel request
        q4.push_back(-1); q4.push_back(1);
        aref_req4 = 1'b1;
        ch_req4   = 4'b0010;
        wait_busy4("aref4");
        tick(); tick();
        aref_req4 = 1'b0;
        aref_end4 = 1'b1;
        tick();
        aref_end4 = 1'b0;
        check("aref4_drop", 64'({aref_en4, ch_en4}), 64'(0));
        wait_busy4("after_aref4");
        tick();
        ch_end4 = 4'b0010;
        ch_req4 = 4'h0;
        tick();
        ch_end4 = 4'h0;
        tick();

        // refresh pending during a grant only raises preempt
        q4.push_back(2);
        ch_req4 = 4'b0100;
        wait_busy4("pre4");
        ch_req4   = 4'h0;
        aref_req4 = 1'b1;
        #1;
        check("preempt4_comb", 64'(preempt4), 64'(1));
        for (int k = 0; k < 3; k++) begin
            tick();
            check("preempt4_hold", 64'({preempt4, ch_en4}), 64'({1'b1, 4'b0100}));
        end
        q4.push_back(-1);
        ch_end4 = 4'b0100;
        tick();
        ch_end4 = 4'h0;
        check("pre4_gap", 64'({aref_en4, ch_en4}), 64'(0));
        tick();
        check("pre4_aref", 64'({aref_en4, ch_en4}), 64'({1'b1, 4'd0}));
        tick();
        aref_req4 = 1'b0;
        aref_end4 = 1'b1;
        tick();
        aref_end4 = 1'b0;
        tick();

        // reset in the middle of a channel 3 grant
        q4.push_back(3);
        ch_req4 = 4'b1000;
        wait_busy4("rst4_grant");
        ch_req4 = 4'h0;
        tick();
        rst4     = 1'b1;
        in_init4 = 1'b1;
        tick();
        check("rst4_clear", 64'({aref_en4, ch_en4, dq_oe4}), 64'(0));
        check("rst4_cur", 64'(cur_ch4), 64'(0));
        rst4    = 1'b0;
        ch_req4 = 4'b1001;
        tick();
        check("rst4_init_noen", 64'(ch_en4), 64'(0));
        init_end4 = 1'b1;
        q4.push_back(0);
        tick();
        in_init4  = 1'b0;
        init_end4 = 1'b0;
        wait_busy4("rst4_regrant");
        tick();
        ch_end4 = 4'b0001;
        ch_req4 = 4'h0;
        tick();
        ch_end4 = 4'h0;
        tick();

        // eight-channel round robin, stray end pulse ignored
        rst8 = 1'b0;
        tick();
        init_end8 = 1'b1;
        tick();
        in_init8 = 1'b0;
        for (int k = 0; k < 9; k++) q8.push_back(k % 8);
        ch_req8 = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            wait_busy8("rr8");
            if (k == 1) begin
                ch_end8 = 8'h20;
                tick();
                ch_end8 = 8'h00;
                check("ignore_end8", 64'(ch_en8), 64'(8'h02));
            end else begin
                tick();
            end
            tick();
            ch_end8 = 8'(1 << (k % 8));
            if (k == 8) ch_req8 = 8'h00;
            tick();
            ch_end8 = 8'h00;
        end

        tick(); tick(); tick();
        check("q4_empty", 64'(q4.size()), 64'(0));
        check("q8_empty", 64'(q8.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
